// File: rtl/gci_std_display_sram_arbiter_if.sv
// Bus bundle between the VRAM requesters, the arbiter and the SRAM cycle engine.
// Handshake: a REQ is a level held with its ADDR/DATA; it is consumed on a cycle whose ACK is 1.
interface gci_std_display_sram_arbiter_if #(
  parameter int P_MEM_ADDR_N = 20
);
  logic                    iRD_REQ;
  logic [P_MEM_ADDR_N-1:0] iRD_ADDR;
  logic                    oRD_ACK;
  logic                    oRD_VALID;
  logic [15:0]             oRD_DATA;
  logic                    iWR0_REQ;
  logic [P_MEM_ADDR_N-1:0] iWR0_ADDR;
  logic [15:0]             iWR0_DATA;
  logic                    oWR0_ACK;
  logic                    iWR1_REQ;
  logic [P_MEM_ADDR_N-1:0] iWR1_ADDR;
  logic [15:0]             iWR1_DATA;
  logic                    oWR1_ACK;
  logic                    oMEM_REQ;
  logic                    iMEM_BUSY;
  logic                    oMEM_RW;
  logic [P_MEM_ADDR_N-1:0] oMEM_ADDR;
  logic [15:0]             oMEM_DATA;
  logic                    iMEM_RD_VALID;
  logic [15:0]             iMEM_RD_DATA;
  logic [1:0]              oGRANT;

  modport slave (
    input  iRD_REQ, iRD_ADDR, iWR0_REQ, iWR0_ADDR, iWR0_DATA,
    input  iWR1_REQ, iWR1_ADDR, iWR1_DATA, iMEM_BUSY, iMEM_RD_VALID, iMEM_RD_DATA,
    output oRD_ACK, oRD_VALID, oRD_DATA, oWR0_ACK, oWR1_ACK,
    output oMEM_REQ, oMEM_RW, oMEM_ADDR, oMEM_DATA, oGRANT
  );

  modport master (
    output iRD_REQ, iRD_ADDR, iWR0_REQ, iWR0_ADDR, iWR0_DATA,
    output iWR1_REQ, iWR1_ADDR, iWR1_DATA, iMEM_BUSY, iMEM_RD_VALID, iMEM_RD_DATA,
    input  oRD_ACK, oRD_VALID, oRD_DATA, oWR0_ACK, oWR1_ACK,
    input  oMEM_REQ, oMEM_RW, oMEM_ADDR, oMEM_DATA, oGRANT
  );
endinterface

// File: rtl/gci_std_display_sram_arbiter.sv
// Burst arbiter sharing one SRAM command port between the display reader (priority)
// and two round-robin writers; oGRANT exposes the FSM state directly.
module gci_std_display_sram_arbiter #(
  parameter int P_MEM_ADDR_N   = 20,
  parameter int P_RD_BURST_MAX = 16,
  parameter int P_WR_BURST_MAX = 8
) (
  input  logic iCLOCK,
  input  logic iRESET,
  gci_std_display_sram_arbiter_if.slave bus
);
  localparam int BURST_MAX = (P_RD_BURST_MAX > P_WR_BURST_MAX) ? P_RD_BURST_MAX : P_WR_BURST_MAX;
  localparam int CNT_W     = $clog2(BURST_MAX + 1);
  localparam logic [CNT_W-1:0] RD_CAP = CNT_W'(P_RD_BURST_MAX);
  localparam logic [CNT_W-1:0] WR_CAP = CNT_W'(P_WR_BURST_MAX);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_WR0  = 2'd2,
    ST_WR1  = 2'd3
  } state_t;

  state_t                  b_state;
  state_t                  b_state_next;
  logic [CNT_W-1:0]        b_burst_cnt;
  logic [CNT_W-1:0]        cnt_inc;
  logic                    b_last_wr;
  logic                    b_rd_valid;
  logic [15:0]             b_rd_data;
  logic                    owner_req;
  logic                    mem_rw;
  logic [P_MEM_ADDR_N-1:0] mem_addr;
  logic [15:0]             mem_data;
  logic                    accept;
  logic                    entering;

  // Command mux: the owner's request is forwarded; IDLE drives an all-zero command.
  always_comb begin
    owner_req = 1'b0;
    mem_rw    = 1'b0;
    mem_addr  = '0;
    mem_data  = '0;
    case (b_state)
      ST_RD: begin
        owner_req = bus.iRD_REQ;
        mem_addr  = bus.iRD_ADDR;
      end
      ST_WR0: begin
        owner_req = bus.iWR0_REQ;
        mem_rw    = 1'b1;
        mem_addr  = bus.iWR0_ADDR;
        mem_data  = bus.iWR0_DATA;
      end
      ST_WR1: begin
        owner_req = bus.iWR1_REQ;
        mem_rw    = 1'b1;
        mem_addr  = bus.iWR1_ADDR;
        mem_data  = bus.iWR1_DATA;
      end
      default: ;
    endcase
  end

  assign accept  = owner_req && !bus.iMEM_BUSY;
  assign cnt_inc = b_burst_cnt + CNT_W'(1);

  always_comb begin
    b_state_next = b_state;
    case (b_state)
      ST_IDLE: begin
        if (bus.iRD_REQ)             b_state_next = ST_RD;
        else if (b_last_wr) begin
          if (bus.iWR0_REQ)          b_state_next = ST_WR0;
          else if (bus.iWR1_REQ)     b_state_next = ST_WR1;
        end else begin
          if (bus.iWR1_REQ)          b_state_next = ST_WR1;
          else if (bus.iWR0_REQ)     b_state_next = ST_WR0;
        end
      end
      ST_RD: begin
        if (!bus.iRD_REQ || (accept && cnt_inc == RD_CAP)) b_state_next = ST_IDLE;
      end
      ST_WR0: begin
        if (!bus.iWR0_REQ || (accept && (cnt_inc == WR_CAP || bus.iRD_REQ))) b_state_next = ST_IDLE;
      end
      ST_WR1: begin
        if (!bus.iWR1_REQ || (accept && (cnt_inc == WR_CAP || bus.iRD_REQ))) b_state_next = ST_IDLE;
      end
      default: b_state_next = ST_IDLE;
    endcase
  end

  // Owners are only entered from IDLE, so this marks the start of every burst.
  assign entering = (b_state == ST_IDLE) && (b_state_next != ST_IDLE);

  always_ff @(posedge iCLOCK) begin
    if (iRESET) begin
      b_state     <= ST_IDLE;
      b_burst_cnt <= '0;
      b_last_wr   <= 1'b1;
      b_rd_valid  <= 1'b0;
      b_rd_data   <= '0;
    end else begin
      b_state    <= b_state_next;
      b_rd_valid <= bus.iMEM_RD_VALID;
      b_rd_data  <= bus.iMEM_RD_DATA;
      if (entering)    b_burst_cnt <= '0;
      else if (accept) b_burst_cnt <= cnt_inc;
      if (entering && b_state_next == ST_WR0)      b_last_wr <= 1'b0;
      else if (entering && b_state_next == ST_WR1) b_last_wr <= 1'b1;
    end
  end

  assign bus.oMEM_REQ  = owner_req;
  assign bus.oMEM_RW   = mem_rw;
  assign bus.oMEM_ADDR = mem_addr;
  assign bus.oMEM_DATA = mem_data;
  assign bus.oRD_ACK   = accept && (b_state == ST_RD);
  assign bus.oWR0_ACK  = accept && (b_state == ST_WR0);
  assign bus.oWR1_ACK  = accept && (b_state == ST_WR1);
  assign bus.oRD_VALID = b_rd_valid;
  assign bus.oRD_DATA  = b_rd_data;
  assign bus.oGRANT    = b_state;
endmodule
